// File: rtl/w_writeback_grf.sv
// W-stage writeback decode and 32x32 general register file with write-through
// read bypass, retired-instruction counter and last-writer PC tracking.
module w_writeback_grf #(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         W_PC,
    input  logic [31:0]         W_Instr,
    input  logic [31:0]         W_DMRD,
    input  logic [31:0]         W_ALUAns,
    input  logic                W_b_jump,
    input  logic [31:0]         W_MDUAns,
    input  logic [31:0]         W_CP0Out,
    input  logic [4:0]          rs_addr,
    input  logic [4:0]          rt_addr,
    output logic [31:0]         rs_data,
    output logic [31:0]         rt_data,
    output logic                wb_en,
    output logic [4:0]          wb_addr,
    output logic [31:0]         wb_data,
    output logic [RETIRE_W-1:0] retire_cnt,
    output logic [31:0]         last_wb_pc
);

    typedef enum logic [2:0] {
        SRC_ALU,
        SRC_MDU,
        SRC_PC8,
        SRC_DMRD,
        SRC_CP0
    } wb_src_t;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        wr;
    wb_src_t     src;
    logic [31:0] pc_plus8;
    logic [31:0] regs [32];
    logic        unused_shamt;

    assign op           = W_Instr[31:26];
    assign rs           = W_Instr[25:21];
    assign rt           = W_Instr[20:16];
    assign rd           = W_Instr[15:11];
    assign funct        = W_Instr[5:0];
    assign unused_shamt = ^W_Instr[10:6];
    assign pc_plus8     = W_PC + 32'd8;

    always_comb begin
        wr      = 1'b0;
        wb_addr = '0;
        src     = SRC_ALU;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
                        wr = 1'b1; wb_addr = rd; src = SRC_ALU;
                    end
                    6'h10, 6'h12: begin
                        wr = 1'b1; wb_addr = rd; src = SRC_MDU;
                    end
                    6'h09: begin
                        wr = 1'b1; wb_addr = rd; src = SRC_PC8;
                    end
                    default: ;
                endcase
            end
            6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h0a, 6'h0b: begin
                wr = 1'b1; wb_addr = rt; src = SRC_ALU;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                wr = 1'b1; wb_addr = rt; src = SRC_DMRD;
            end
            6'h03: begin
                wr = 1'b1; wb_addr = 5'd31; src = SRC_PC8;
            end
            6'h10: begin
                if (rs == 5'h00) begin
                    wr = 1'b1; wb_addr = rt; src = SRC_CP0;
                end
            end
            6'h01: begin
                // bltzal/bgezal link only when the branch was actually taken
                if ((rt == 5'h11 || rt == 5'h10) && W_b_jump) begin
                    wr = 1'b1; wb_addr = 5'd31; src = SRC_PC8;
                end
            end
            default: ;
        endcase
        if (W_Instr == '0) begin
            wr      = 1'b0;
            wb_addr = '0;
        end
    end

    always_comb begin
        case (src)
            SRC_MDU:  wb_data = W_MDUAns;
            SRC_PC8:  wb_data = pc_plus8;
            SRC_DMRD: wb_data = W_DMRD;
            SRC_CP0:  wb_data = W_CP0Out;
            default:  wb_data = W_ALUAns;
        endcase
    end

    assign wb_en = wr && (wb_addr != 5'd0);

    always_comb begin
        if (rs_addr == 5'd0)
            rs_data = '0;
        else if (wb_en && rs_addr == wb_addr)
            rs_data = wb_data;
        else
            rs_data = regs[rs_addr];

        if (rt_addr == 5'd0)
            rt_data = '0;
        else if (wb_en && rt_addr == wb_addr)
            rt_data = wb_data;
        else
            rt_data = regs[rt_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++)
                regs[i[4:0]] <= '0;
            retire_cnt <= '0;
            last_wb_pc <= '0;
        end else begin
            if (wb_en) begin
                regs[wb_addr] <= wb_data;
                last_wb_pc    <= W_PC;
            end
            if (W_Instr != '0)
                retire_cnt <= retire_cnt + RETIRE_W'(1);
        end
    end

endmodule
